// File: rtl/feistel_decrypt.sv
// ---------------------------------------------------------------------------
// feistel_decrypt
//   Sixteen-round Blowfish-style Feistel decryption engine. The P-array and
//   the four S-boxes live in two identical external synchronous SRAMs
//   (A and B). Each round takes three cycles (RD_P, F0, F1), so a decrypt
//   accepted in cycle 0 pulses done in cycle 50.
//
//   SRAM layout: S0 @ 0, S1 @ 256, S2 @ 512, S3 @ 768,
//                P[0..17] @ P_ARRAY_OFFSET .. P_ARRAY_OFFSET+17.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start             decrypt request, honoured only in IDLE
//   L, R              ciphertext halves, captured when start is accepted
//   addr_a / addr_b   SRAM read addresses (0 whenever no read is issued)
//   data_a / data_b   SRAM read data, valid the cycle after the address
//   cs_*_l, we_*_l, oe_*_l   active-low SRAM controls (read-only usage)
//   resultL, resultR  plaintext halves, held until the next decrypt ends
//   done              one-cycle completion pulse
//   busy              high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module feistel_decrypt #(
  parameter int P_ARRAY_OFFSET = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] L,
  input  logic [31:0] R,
  output logic [11:0] addr_a,
  input  logic [31:0] data_a,
  output logic        cs_a_l,
  output logic        we_a_l,
  output logic        oe_a_l,
  output logic [11:0] addr_b,
  input  logic [31:0] data_b,
  output logic        cs_b_l,
  output logic        we_b_l,
  output logic        oe_b_l,
  output logic [31:0] resultL,
  output logic [31:0] resultR,
  output logic        done,
  output logic        busy
);

  localparam logic [11:0] P_BASE = 12'(P_ARRAY_OFFSET);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_P  = 3'd1,
    F0    = 3'd2,
    F1    = 3'd3,
    FINAL = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] lreg_q, lreg_d;
  logic [31:0] rreg_q, rreg_d;
  logic [31:0] fr_q, fr_d;
  logic [31:0] resl_q, resl_d;
  logic [31:0] resr_q, resr_d;

  // Left half after the P-word xor; used both as the stored value and,
  // combinationally, as the S0/S1 index source in the same cycle.
  logic [31:0] t_w;
  assign t_w = lreg_q ^ data_a;

  // Completes F = ((S0 + S1) ^ S2) + S3 and folds it into the right half.
  function automatic logic [31:0] round_mix(input logic [31:0] s01,
                                            input logic [31:0] s2,
                                            input logic [31:0] s3,
                                            input logic [31:0] rhalf);
    return rhalf ^ ((s01 ^ s2) + s3);
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lreg_q  <= '0;
      rreg_q  <= '0;
      fr_q    <= '0;
      resl_q  <= '0;
      resr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lreg_q  <= lreg_d;
      rreg_q  <= rreg_d;
      fr_q    <= fr_d;
      resl_q  <= resl_d;
      resr_q  <= resr_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lreg_d  = lreg_q;
    rreg_d  = rreg_q;
    fr_d    = fr_q;
    resl_d  = resl_q;
    resr_d  = resr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          lreg_d  = L;
          rreg_d  = R;
          cnt_d   = '0;
          state_d = RD_P;
        end
      end
      RD_P: begin
        lreg_d  = t_w;
        state_d = F0;
      end
      F0: begin
        fr_d    = data_a + data_b;
        state_d = F1;
      end
      F1: begin
        // Swap halves while applying F to the old right half.
        lreg_d = round_mix(fr_q, data_a, data_b, rreg_q);
        rreg_d = lreg_q;
        if (cnt_q != 4'd15) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = RD_P;
        end else begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        // The last swap is undone here: P[0] (port B) whitens the right
        // register into resultL, P[1] (port A) the left into resultR.
        resl_d  = rreg_q ^ data_b;
        resr_d  = lreg_q ^ data_a;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: SRAM addressing and status
  always_comb begin
    cs_a_l = 1'b1;
    cs_b_l = 1'b1;
    addr_a = '0;
    addr_b = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cs_a_l = 1'b0;
          addr_a = P_BASE + 12'd17;
        end
      end
      RD_P: begin
        cs_a_l = 1'b0;
        cs_b_l = 1'b0;
        addr_a = {4'b0, t_w[31:24]};
        addr_b = 12'd256 + {4'b0, t_w[23:16]};
      end
      F0: begin
        cs_a_l = 1'b0;
        cs_b_l = 1'b0;
        addr_a = 12'd512 + {4'b0, lreg_q[15:8]};
        addr_b = 12'd768 + {4'b0, lreg_q[7:0]};
      end
      F1: begin
        cs_a_l = 1'b0;
        if (cnt_q != 4'd15) begin
          addr_a = P_BASE + 12'd16 - {8'b0, cnt_q};
        end else begin
          cs_b_l = 1'b0;
          addr_a = P_BASE + 12'd1;
          addr_b = P_BASE;
        end
      end
      default: ;
    endcase
    // Reset must silence the ports immediately, even if start is high.
    if (reset) begin
      cs_a_l = 1'b1;
      cs_b_l = 1'b1;
      addr_a = '0;
      addr_b = '0;
    end
  end

  assign we_a_l  = 1'b1;
  assign we_b_l  = 1'b1;
  assign oe_a_l  = 1'b0;
  assign oe_b_l  = 1'b0;
  assign done    = (state_q == DONE) && !reset;
  assign busy    = (state_q != IDLE) && !reset;
  assign resultL = resl_q;
  assign resultR = resr_q;

endmodule

// File: tb/tb_feistel_decrypt.sv
module tb_feistel_decrypt;

  localparam int P_OFF = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] L, R;
  logic [11:0] addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        cs_a_l, we_a_l, oe_a_l;
  logic        cs_b_l, we_b_l, oe_b_l;
  logic [31:0] resultL, resultR;
  logic        done, busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4096];
  logic [63:0] sb [$];
  logic [63:0] last_res;
  logic        ctrl_bad;

  feistel_decrypt #(.P_ARRAY_OFFSET(P_OFF)) dut (
    .clk(clk), .reset(reset), .start(start), .L(L), .R(R),
    .addr_a(addr_a), .data_a(data_a), .cs_a_l(cs_a_l), .we_a_l(we_a_l), .oe_a_l(oe_a_l),
    .addr_b(addr_b), .data_b(data_b), .cs_b_l(cs_b_l), .we_b_l(we_b_l), .oe_b_l(oe_b_l),
    .resultL(resultL), .resultR(resultR), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM pair holding identical contents
  always @(posedge clk) begin
    if (!cs_a_l) data_a <= mem[addr_a];
    if (!cs_b_l) data_b <= mem[addr_b];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Static port rules: write disabled, output enabled, idle address zero
  always @(negedge clk) begin
    if (we_a_l !== 1'b1 || we_b_l !== 1'b1 || oe_a_l !== 1'b0 || oe_b_l !== 1'b0 ||
        (cs_a_l && addr_a !== 12'd0) || (cs_b_l && addr_b !== 12'd0))
      ctrl_bad <= 1'b1;
  end

  // Scoreboard: pop one expected result per done pulse
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {63'b0, done}, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("result", {resultL, resultR}, e);
      end
    end
  end

  function automatic logic [31:0] pword(input int i);
    return mem[P_OFF + i];
  endfunction

  function automatic logic [31:0] ffn(input logic [31:0] x);
    return ((mem[x[31:24]] + mem[256 + x[23:16]]) ^ mem[512 + x[15:8]]) + mem[768 + x[7:0]];
  endfunction

  // Reference forward cipher; decrypting its output must give the plaintext.
  function automatic logic [63:0] encrypt(input logic [31:0] pl, input logic [31:0] pr);
    logic [31:0] xl, xr, tmp;
    xl = pl;
    xr = pr;
    for (int i = 0; i < 16; i++) begin
      xl  = xl ^ pword(i);
      xr  = xr ^ ffn(xl);
      tmp = xl; xl = xr; xr = tmp;
    end
    tmp = xl; xl = xr; xr = tmp;
    xr = xr ^ pword(16);
    xl = xl ^ pword(17);
    return {xl, xr};
  endfunction

  task automatic fill_zero();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
  endtask

  // One decrypt from IDLE; extra start pulses at cycles p1/p2 (0 = none)
  task automatic run_one(input logic [31:0] cl, input logic [31:0] cr,
                         input logic [31:0] pl, input logic [31:0] pr,
                         input int p1, input int p2);
    int got;
    got = 0;
    @(posedge clk); #1;
    L = cl; R = cr; start = 1'b1;
    sb.push_back({pl, pr});
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      start = (k == p1) || (k == p2);
      L = $urandom; R = $urandom;
      @(negedge clk);
      if (k == 1) begin
        check("busy_c1", {63'b0, busy}, 64'd1);
        check("hold_c1", {resultL, resultR}, last_res);
      end
      if (done === 1'b1) begin
        got = k;
        break;
      end
    end
    check("done_cycle", 64'(got), 64'd50);
    last_res = {pl, pr};
  endtask

  initial begin
    logic [63:0] c;
    logic [31:0] pl, pr;
    ctrl_bad = 1'b0;
    last_res = 64'd0;
    reset = 1'b1;
    start = 1'b0;
    L = 32'h0; R = 32'h0;
    fill_zero();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_cs", {62'b0, cs_a_l, cs_b_l}, 64'd3);
    check("rst_addr", {40'b0, addr_a, addr_b}, 64'd0);
    check("rst_res", {resultL, resultR}, 64'd0);
    reset = 1'b0;

    // All-zero SRAM: sixteen swaps cancel, final swap exchanges halves
    run_one(32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'h12345678, 0, 0);

    // Only P[17] set: lands in the right-hand output
    mem[P_OFF + 17] = 32'h00000001;
    run_one(32'h0, 32'h0, 32'h0, 32'h00000001, 0, 0);

    // Extra starts while busy and during DONE are ignored
    fill_random();
    pl = $urandom; pr = $urandom;
    c = encrypt(pl, pr);
    run_one(c[63:32], c[31:0], pl, pr, 5, 50);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("done_start_ignored", {63'b0, busy}, 64'd0);
    check("res_after_ignore", {resultL, resultR}, {pl, pr});

    // Reset in cycle 20 aborts the operation
    pl = $urandom; pr = $urandom;
    c = encrypt(pl, pr);
    @(posedge clk); #1;
    L = c[63:32]; R = c[31:0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    check("abort_cs", {62'b0, cs_a_l, cs_b_l}, 64'd3);
    check("abort_addr", {40'b0, addr_a, addr_b}, 64'd0);
    check("abort_res", {resultL, resultR}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    last_res = 64'd0;
    repeat (60) @(negedge clk);
    check("abort_idle", {63'b0, busy}, 64'd0);
    run_one(c[63:32], c[31:0], pl, pr, 0, 0);

    // Back-to-back random key schedules and plaintexts
    for (int v = 0; v < 1000; v++) begin
      if (v % 100 == 0) fill_random();
      pl = $urandom; pr = $urandom;
      c = encrypt(pl, pr);
      run_one(c[63:32], c[31:0], pl, pr, 0, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("port_rules", {63'b0, ctrl_bad}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/feistel_decrypt.md
FEISTEL_DECRYPT -- requirements
Module: feistel_decrypt

Interface
REQ-001 The block SHALL have parameter P_ARRAY_OFFSET, default 4000, which is the SRAM word address of P[0]; P[0..17] occupy P_ARRAY_OFFSET..P_ARRAY_OFFSET+17.
REQ-002 The block SHALL place S-boxes at SRAM words 0..1023: S0 at 0, S1 at 256, S2 at 512, S3 at 768.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to decrypt; sampled only in IDLE.
REQ-006 L, R  in  32 each  ciphertext halves; captured on the accepted start cycle.
REQ-007 addr_a  out  12  SRAM A read address.
REQ-008 data_a  in  32  SRAM A read data.
REQ-009 cs_a_l, we_a_l, oe_a_l  out  1 each  SRAM A controls, active-low.
REQ-010 addr_b, data_b, cs_b_l, we_b_l, oe_b_l  SHALL mirror the port A set for SRAM B.
REQ-011 resultL, resultR  out  32 each  plaintext halves.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 The SRAMs SHALL be treated as synchronous: an address issued with cs_x_l=0 in cycle n returns data on data_x in cycle n+1.
REQ-015 we_a_l and we_b_l SHALL be 1 at all times; oe_a_l and oe_b_l SHALL be 0 at all times.
REQ-016 cs_x_l SHALL be 0 only in cycles that issue a read on that port; addr_x SHALL be 0 in all other cycles.
REQ-017 The FSM SHALL have the states IDLE, RD_P, F0, F1, FINAL and DONE.
REQ-018 IDLE with start=1: the block SHALL capture Lreg=L, Rreg=R, round counter cnt=0, issue addr_a=P_ARRAY_OFFSET+17, and go to RD_P; with start=0 it SHALL remain in IDLE.
REQ-019 RD_P: the block SHALL compute t=Lreg^data_a, store Lreg<=t, issue addr_a={4'b0,t[31:24]} and addr_b=256+t[23:16] (t combinational), and go to F0.
REQ-020 F0: the block SHALL store F_r<=data_a+data_b (mod 2^32), issue addr_a=512+Lreg[15:8] and addr_b=768+Lreg[7:0], and go to F1.
REQ-021 F1: the block SHALL load Lreg<=Rreg^((F_r^data_a)+data_b) (sum mod 2^32) and Rreg<=Lreg.
REQ-022 F1 with cnt<15: cnt SHALL increment, addr_a SHALL be P_ARRAY_OFFSET+16-cnt (old cnt), and the next state SHALL be RD_P.
REQ-023 F1 with cnt=15: the block SHALL issue addr_a=P_ARRAY_OFFSET+1 and addr_b=P_ARRAY_OFFSET+0, and go to FINAL.
REQ-024 The P-index sequence SHALL therefore be 17,16,...,2, one per round, for 16 rounds.
REQ-025 FINAL: the block SHALL set resultL<=Rreg^data_b and resultR<=Lreg^data_a, and go to DONE.
REQ-026 DONE: done SHALL be 1 for exactly this cycle, then the FSM SHALL go to IDLE.
REQ-027 Latency: with start accepted in cycle 0, rounds SHALL occupy cycles 1..48, FINAL cycle 49, and done=1 in cycle 50 with results valid.
REQ-028 resultL and resultR SHALL hold their values until the next FINAL.
REQ-029 start while busy=1 SHALL be ignored with no effect on the operation in progress.
REQ-030 start asserted in the same cycle as DONE SHALL be ignored; it is accepted only from IDLE on the next cycle.
REQ-031 L and R changing after capture SHALL have no effect.

Reset
REQ-032 While reset=1 the block SHALL asynchronously force:
- state=IDLE, cnt=0, Lreg=Rreg=F_r=0
- resultL=resultR=0
- done=0, busy=0
- cs_a_l=cs_b_l=1, addr_a=addr_b=0
REQ-033 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow.
REQ-034 After reset deasserts, the next start SHALL run a full, correct 50-cycle decrypt.

Verification
REQ-035 All SRAM words zero, L=0x12345678, R=0x9ABCDEF0, start -> done in cycle 50, resultL=0x9ABCDEF0, resultR=0x12345678.
REQ-036 S-boxes zero, P[17]=0x00000001, other P zero, L=R=0, start -> resultL=0x00000000, resultR=0x00000001.
REQ-037 SRAMs loaded with the key schedule for the all-zero key, L=0x4EF99745, R=0x6198DD78 -> resultL=0x00000000, resultR=0x00000000; the address trace SHALL match REQ-018..REQ-023 every cycle.
REQ-038 Random key schedule and plaintext, encrypted by the software model, then decrypted -> plaintext recovered; repeat for 1000 vectors back-to-back.
REQ-039 Second start pulsed in cycles 5 and 50 -> both ignored, a single done, results unchanged; a start in cycle 51 runs normally.
REQ-040 Reset asserted in cycle 20 for 1 cycle -> outputs take the REQ-032 values immediately, no done pulse, and the following decrypt is correct.
